// File: rtl/csr_trap_if.sv
// Instruction-side bus between the core and the machine-mode CSR/trap unit.
interface csr_trap_if;
  logic [31:0] pc;
  logic        csr_en;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  uimm;
  logic        ecall;
  logic        mret;
  logic [31:0] csr_rdata;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [1:0]  pc_sel;

  // Core side: drives instruction info, receives CSR data and redirect select
  modport master (
    output pc, csr_en, csr_op, csr_addr, rs1_data, uimm, ecall, mret,
    input  csr_rdata, mtvec, mepc, pc_sel
  );

  // CSR unit side
  modport slave (
    input  pc, csr_en, csr_op, csr_addr, rs1_data, uimm, ecall, mret,
    output csr_rdata, mtvec, mepc, pc_sel
  );
endinterface

// File: rtl/csr_trap.sv
// Machine-mode CSR file with ecall/mret trap handling and a 64-bit cycle counter.
module csr_trap #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] MARCHID   = 32'h0178_BFFB
) (
  input  logic       clk,
  input  logic       rst,
  csr_trap_if.slave  bus
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [31:0] MVENDORID   = 32'h7973_7978;
  localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic        r_mie;
  logic        r_mpie;
  logic [63:0] r_mcycle;

  logic [31:0] w_mstatus;
  logic [31:0] w_old;
  logic [31:0] w_operand;
  logic [31:0] w_new;
  logic        w_op_wr;
  logic        w_wr;

  // MPP is hardwired to machine mode; only MIE/MPIE are stored
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};

  // Old-value read mux; unimplemented addresses read as zero
  always_comb begin
    w_old = 32'h0;
    case (bus.csr_addr)
      A_MSTATUS:   w_old = w_mstatus;
      A_MTVEC:     w_old = r_mtvec;
      A_MEPC:      w_old = r_mepc;
      A_MCAUSE:    w_old = r_mcause;
      A_MCYCLE:    w_old = r_mcycle[31:0];
      A_MCYCLEH:   w_old = r_mcycle[63:32];
      A_MVENDORID: w_old = MVENDORID;
      A_MARCHID:   w_old = MARCHID;
      default:     w_old = 32'h0;
    endcase
  end

  assign w_operand = bus.csr_op[2] ? {27'b0, bus.uimm} : bus.rs1_data;

  // New-value computation; set/clear with a zero operand is not a write
  always_comb begin
    w_new   = w_operand;
    w_op_wr = 1'b0;
    case (bus.csr_op[1:0])
      2'b01: begin
        w_new   = w_operand;
        w_op_wr = 1'b1;
      end
      2'b10: begin
        w_new   = w_old | w_operand;
        w_op_wr = (w_operand != 32'h0);
      end
      2'b11: begin
        w_new   = w_old & ~w_operand;
        w_op_wr = (w_operand != 32'h0);
      end
      default: begin
        w_new   = w_operand;
        w_op_wr = 1'b0;
      end
    endcase
  end

  // Trap events take priority and suppress any CSR write in the same cycle
  assign w_wr = bus.csr_en & w_op_wr & ~bus.ecall & ~bus.mret;

  // Trap/CSR state: ecall > mret > software write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtvec  <= MTVEC_RST;
      r_mepc   <= 32'h0;
      r_mcause <= 32'h0;
      r_mie    <= MSTATUS_RST[3];
      r_mpie   <= MSTATUS_RST[7];
    end else if (bus.ecall) begin
      r_mepc   <= bus.pc;
      r_mcause <= 32'd11;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (bus.mret) begin
      r_mie    <= r_mpie;
      r_mpie   <= 1'b1;
    end else if (w_wr) begin
      case (bus.csr_addr)
        A_MSTATUS: begin
          r_mie  <= w_new[3];
          r_mpie <= w_new[7];
        end
        A_MTVEC:  r_mtvec  <= {w_new[31:2], 2'b00};
        A_MEPC:   r_mepc   <= {w_new[31:2], 2'b00};
        A_MCAUSE: r_mcause <= w_new;
        default:  ;
      endcase
    end
  end

  // Free-running cycle counter; a software write replaces one half and freezes the other
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcycle <= 64'h0;
    end else if (w_wr && (bus.csr_addr == A_MCYCLE)) begin
      r_mcycle <= {r_mcycle[63:32], w_new};
    end else if (w_wr && (bus.csr_addr == A_MCYCLEH)) begin
      r_mcycle <= {w_new, r_mcycle[31:0]};
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end

  // Same-cycle redirect select: trap vector on ecall, return address on mret
  always_comb begin
    bus.pc_sel = 2'b00;
    if (bus.ecall) begin
      bus.pc_sel = 2'b01;
    end else if (bus.mret) begin
      bus.pc_sel = 2'b11;
    end
  end

  assign bus.csr_rdata = w_old;
  assign bus.mtvec     = r_mtvec;
  assign bus.mepc      = r_mepc;

endmodule

// File: tb/tb_csr_trap.sv
// Directed self-checking bench for csr_trap.
module tb_csr_trap;

  localparam logic [31:0] TB_MTVEC_RST = 32'h0000_0200;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  csr_trap_if bus_if ();

  csr_trap #(.MTVEC_RST(TB_MTVEC_RST), .MARCHID(32'h0178_BFFB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one instruction cycle's worth of inputs at the falling edge
  task automatic drive(input logic en, input logic [2:0] op, input logic [11:0] addr,
                       input logic [31:0] rs1, input logic [4:0] imm,
                       input logic ec, input logic mr, input logic [31:0] pcv);
    @(negedge clk);
    bus_if.csr_en   = en;
    bus_if.csr_op   = op;
    bus_if.csr_addr = addr;
    bus_if.rs1_data = rs1;
    bus_if.uimm     = imm;
    bus_if.ecall    = ec;
    bus_if.mret     = mr;
    bus_if.pc       = pcv;
    #1;
  endtask

  task automatic csr(input logic [2:0] op, input logic [11:0] addr,
                     input logic [31:0] rs1, input logic [4:0] imm);
    drive(1'b1, op, addr, rs1, imm, 1'b0, 1'b0, 32'h0);
  endtask

  // Plain read: RS with a zero register operand
  task automatic rd(input logic [11:0] addr);
    drive(1'b1, 3'b010, addr, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 12'h000, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus_if.mtvec !== TB_MTVEC_RST) begin bad++; $display("FAIL reset_mtvec got=%h exp=%h", bus_if.mtvec, TB_MTVEC_RST); end
    total++; if (bus_if.mepc !== 32'h0) begin bad++; $display("FAIL reset_mepc got=%h exp=%h", bus_if.mepc, 32'h0); end
    total++; if (bus_if.pc_sel !== 2'b00) begin bad++; $display("FAIL reset_pc_sel got=%b exp=00", bus_if.pc_sel); end
    rd(12'h300);
    total++; if (bus_if.csr_rdata !== 32'h0000_1800) begin bad++; $display("FAIL reset_mstatus got=%h exp=%h", bus_if.csr_rdata, 32'h0000_1800); end
    rd(12'hB00);
    total++; if (bus_if.csr_rdata !== 32'h0) begin bad++; $display("FAIL reset_mcycle_held got=%h exp=0", bus_if.csr_rdata); end
    @(negedge clk);
    rst = 1'b0;
    rd(12'hB00);
    total++; if (bus_if.csr_rdata !== 32'd1) begin bad++; $display("FAIL first_increment got=%h exp=1", bus_if.csr_rdata); end
  endtask

  task automatic test_csr_write();
    csr(3'b001, 12'h305, 32'h8000_0103, 5'd0);
    total++; if (bus_if.csr_rdata !== TB_MTVEC_RST) begin bad++; $display("FAIL rw_old_value got=%h exp=%h", bus_if.csr_rdata, TB_MTVEC_RST); end
    idle();
    total++; if (bus_if.mtvec !== 32'h8000_0100) begin bad++; $display("FAIL rw_mtvec got=%h exp=%h", bus_if.mtvec, 32'h8000_0100); end
    csr(3'b010, 12'h305, 32'h0, 5'd0);
    idle();
    total++; if (bus_if.mtvec !== 32'h8000_0100) begin bad++; $display("FAIL rs_zero_mtvec got=%h exp=%h", bus_if.mtvec, 32'h8000_0100); end
    csr(3'b011, 12'h305, 32'h8000_0000, 5'd0);
    idle();
    total++; if (bus_if.mtvec !== 32'h0000_0100) begin bad++; $display("FAIL rc_mtvec got=%h exp=%h", bus_if.mtvec, 32'h0000_0100); end
    csr(3'b110, 12'h305, 32'hFFFF_FFFF, 5'h1F);
    idle();
    total++; if (bus_if.mtvec !== 32'h0000_011C) begin bad++; $display("FAIL rsi_mtvec got=%h exp=%h", bus_if.mtvec, 32'h0000_011C); end
    csr(3'b001, 12'h341, 32'h1234_5677, 5'd0);
    idle();
    total++; if (bus_if.mepc !== 32'h1234_5674) begin bad++; $display("FAIL rw_mepc_align got=%h exp=%h", bus_if.mepc, 32'h1234_5674); end
    csr(3'b001, 12'h342, 32'hDEAD_BEEF, 5'd0);
    rd(12'h342);
    total++; if (bus_if.csr_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rw_mcause got=%h exp=%h", bus_if.csr_rdata, 32'hDEAD_BEEF); end
  endtask

  task automatic test_trap();
    csr(3'b110, 12'h300, 32'h0, 5'd8);
    rd(12'h300);
    total++; if (bus_if.csr_rdata !== 32'h0000_1808) begin bad++; $display("FAIL set_mie got=%h exp=%h", bus_if.csr_rdata, 32'h0000_1808); end
    drive(1'b0, 3'b000, 12'h000, 32'h0, 5'd0, 1'b1, 1'b0, 32'h8000_0040);
    total++; if (bus_if.pc_sel !== 2'b01) begin bad++; $display("FAIL ecall_pc_sel got=%b exp=01", bus_if.pc_sel); end
    rd(12'h342);
    total++; if (bus_if.csr_rdata !== 32'd11) begin bad++; $display("FAIL ecall_mcause got=%h exp=%h", bus_if.csr_rdata, 32'd11); end
    total++; if (bus_if.mepc !== 32'h8000_0040) begin bad++; $display("FAIL ecall_mepc got=%h exp=%h", bus_if.mepc, 32'h8000_0040); end
    rd(12'h300);
    total++; if (bus_if.csr_rdata !== 32'h0000_1880) begin bad++; $display("FAIL ecall_mstatus got=%h exp=%h", bus_if.csr_rdata, 32'h0000_1880); end
    drive(1'b0, 3'b000, 12'h000, 32'h0, 5'd0, 1'b0, 1'b1, 32'h8000_0200);
    total++; if (bus_if.pc_sel !== 2'b11) begin bad++; $display("FAIL mret_pc_sel got=%b exp=11", bus_if.pc_sel); end
    total++; if (bus_if.mepc !== 32'h8000_0040) begin bad++; $display("FAIL mret_mepc got=%h exp=%h", bus_if.mepc, 32'h8000_0040); end
    rd(12'h300);
    total++; if (bus_if.csr_rdata !== 32'h0000_1888) begin bad++; $display("FAIL mret_mstatus got=%h exp=%h", bus_if.csr_rdata, 32'h0000_1888); end
    idle();
    total++; if (bus_if.pc_sel !== 2'b00) begin bad++; $display("FAIL idle_pc_sel got=%b exp=00", bus_if.pc_sel); end
  endtask

  task automatic test_counter();
    csr(3'b001, 12'hB80, 32'h0, 5'd0);
    csr(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd0);
    rd(12'hB00);
    total++; if (bus_if.csr_rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cyc_written got=%h exp=%h", bus_if.csr_rdata, 32'hFFFF_FFFF); end
    csr(3'b110, 12'hB00, 32'h0, 5'd0);
    total++; if (bus_if.csr_rdata !== 32'h0) begin bad++; $display("FAIL cyc_carry_lo got=%h exp=0", bus_if.csr_rdata); end
    rd(12'hB80);
    total++; if (bus_if.csr_rdata !== 32'd1) begin bad++; $display("FAIL cyc_carry_hi got=%h exp=1", bus_if.csr_rdata); end
    rd(12'hB00);
    total++; if (bus_if.csr_rdata !== 32'd2) begin bad++; $display("FAIL cyc_rsi_zero_running got=%h exp=2", bus_if.csr_rdata); end
    csr(3'b001, 12'hB80, 32'hFFFF_FFFF, 5'd0);
    csr(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd0);
    rd(12'hB80);
    total++; if (bus_if.csr_rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cyc_hi_hold got=%h exp=%h", bus_if.csr_rdata, 32'hFFFF_FFFF); end
    rd(12'hB00);
    total++; if (bus_if.csr_rdata !== 32'h0) begin bad++; $display("FAIL cyc_wrap_lo got=%h exp=0", bus_if.csr_rdata); end
    rd(12'hB80);
    total++; if (bus_if.csr_rdata !== 32'h0) begin bad++; $display("FAIL cyc_wrap_hi got=%h exp=0", bus_if.csr_rdata); end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 3'b001, 12'h341, 32'h0000_1234, 5'd0, 1'b1, 1'b1, 32'h8000_0080);
    total++; if (bus_if.pc_sel !== 2'b01) begin bad++; $display("FAIL sim_pc_sel got=%b exp=01", bus_if.pc_sel); end
    rd(12'h341);
    total++; if (bus_if.csr_rdata !== 32'h8000_0080) begin bad++; $display("FAIL sim_mepc got=%h exp=%h", bus_if.csr_rdata, 32'h8000_0080); end
    rd(12'h300);
    total++; if (bus_if.csr_rdata !== 32'h0000_1880) begin bad++; $display("FAIL sim_mstatus got=%h exp=%h", bus_if.csr_rdata, 32'h0000_1880); end
    drive(1'b1, 3'b001, 12'h305, 32'hAAAA_0000, 5'd0, 1'b0, 1'b1, 32'h0);
    total++; if (bus_if.pc_sel !== 2'b11) begin bad++; $display("FAIL mret_wr_pc_sel got=%b exp=11", bus_if.pc_sel); end
    idle();
    total++; if (bus_if.mtvec !== 32'h0000_011C) begin bad++; $display("FAIL mret_wr_discard got=%h exp=%h", bus_if.mtvec, 32'h0000_011C); end
    csr(3'b001, 12'h7C0, 32'hFFFF_FFFF, 5'd0);
    rd(12'h7C0);
    total++; if (bus_if.csr_rdata !== 32'h0) begin bad++; $display("FAIL unimpl_read got=%h exp=0", bus_if.csr_rdata); end
    csr(3'b001, 12'hF11, 32'h0, 5'd0);
    rd(12'hF11);
    total++; if (bus_if.csr_rdata !== 32'h7973_7978) begin bad++; $display("FAIL mvendorid_ro got=%h exp=%h", bus_if.csr_rdata, 32'h7973_7978); end
    rd(12'hF12);
    total++; if (bus_if.csr_rdata !== 32'h0178_BFFB) begin bad++; $display("FAIL marchid got=%h exp=%h", bus_if.csr_rdata, 32'h0178_BFFB); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 3'b010, 12'h300, 32'h0, 5'd0, 1'b1, 1'b0, 32'h8000_0100);
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus_if.mepc !== 32'h0) begin bad++; $display("FAIL async_mepc got=%h exp=0", bus_if.mepc); end
    total++; if (bus_if.mtvec !== TB_MTVEC_RST) begin bad++; $display("FAIL async_mtvec got=%h exp=%h", bus_if.mtvec, TB_MTVEC_RST); end
    total++; if (bus_if.csr_rdata !== 32'h0000_1800) begin bad++; $display("FAIL async_mstatus got=%h exp=%h", bus_if.csr_rdata, 32'h0000_1800); end
    bus_if.csr_addr = 12'h342;
    #1;
    total++; if (bus_if.csr_rdata !== 32'h0) begin bad++; $display("FAIL async_mcause got=%h exp=0", bus_if.csr_rdata); end
    @(negedge clk);
    rst = 1'b0;
    bus_if.ecall = 1'b0;
    rd(12'hB00);
    total++; if (bus_if.csr_rdata !== 32'd1) begin bad++; $display("FAIL async_release_mcycle got=%h exp=1", bus_if.csr_rdata); end
    total++; if (bus_if.mepc !== 32'h0) begin bad++; $display("FAIL async_discard_ecall got=%h exp=0", bus_if.mepc); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus_if.csr_en   = 1'b0;
    bus_if.csr_op   = 3'b000;
    bus_if.csr_addr = 12'h000;
    bus_if.rs1_data = 32'h0;
    bus_if.uimm     = 5'd0;
    bus_if.ecall    = 1'b0;
    bus_if.mret     = 1'b0;
    bus_if.pc       = 32'h0;
    test_reset();
    test_csr_write();
    test_trap();
    test_counter();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_trap.md
CSR_TRAP -- requirements
Module: csr_trap

Interface
REQ-001 The module SHALL have parameter MTVEC_RST, default 32'h00000000, as the mtvec reset value.
REQ-002 The module SHALL have parameter MARCHID, default 32'h0178_BFFB, as the read-only marchid value.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 pc  in  32  address of the instruction currently executing.
REQ-006 csr_en  in  1  a CSR instruction is executing this cycle.
REQ-007 csr_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
REQ-008 csr_addr  in  12  CSR address.
REQ-009 rs1_data  in  32  register operand for RW/RS/RC.
REQ-010 uimm  in  5  zero-extended immediate operand for RWI/RSI/RCI.
REQ-011 ecall  in  1  environment call executing this cycle.
REQ-012 mret  in  1  trap return executing this cycle.
REQ-013 csr_rdata  out  32  old CSR value; combinational from csr_addr.
REQ-014 mtvec  out  32  current mtvec register.
REQ-015 mepc  out  32  current mepc register.
REQ-016 pc_sel  out  2  next-PC select: 00 sequential/branch adder, 01 mtvec, 11 mepc; 10 is never driven.

Function
REQ-017 The implemented CSRs SHALL be: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80, mvendorid 0xF11 (read-only), marchid 0xF12 (read-only).
REQ-018 The mvendorid register SHALL read as 32'h7973_7978, and marchid SHALL read as MARCHID.
REQ-019 A read of an unimplemented address SHALL return 0, and a write to it SHALL be ignored.
REQ-020 Writes to read-only CSRs SHALL be ignored.
REQ-021 The write operand SHALL be rs1_data for csr_op[2]=0 and {27'b0,uimm} for csr_op[2]=1.
REQ-022 The new value SHALL be: RW = operand; RS = old | operand; RC = old & ~operand.
REQ-023 An RS or RC with operand 0 SHALL leave the CSR unchanged.
REQ-024 A CSR write SHALL take effect at the rising edge ending the instruction cycle.
REQ-025 csr_rdata SHALL always reflect the pre-write value.
REQ-026 mtvec SHALL be direct mode only; a write to mtvec SHALL store bits [1:0] as 0.
REQ-027 A write to mepc SHALL store bits [1:0] as 0.
REQ-028 mstatus SHALL implement MIE[3], MPIE[7] and MPP[12:11]; other bits SHALL read 0.
REQ-029 MPP SHALL be hardwired to 2'b11.
REQ-030 mcycle/mcycleh SHALL form a 64-bit counter that increments by 1 every cycle out of reset.
REQ-031 The low-word carry SHALL propagate into mcycleh, so 0xFFFFFFFF wraps to 0 with mcycleh+1.
REQ-032 A full 64-bit wrap SHALL return the counter to 0.
REQ-033 A software write to mcycle or mcycleh SHALL replace that half in place of the increment for that cycle.
REQ-034 The half that was not written SHALL hold its value in that cycle (no carry).
REQ-035 On ecall, the module SHALL drive pc_sel=01 in the same cycle.
REQ-036 On the ecall edge: mepc<=pc; mcause<=32'd11; MPIE<=MIE; MIE<=0.
REQ-037 On mret, the module SHALL drive pc_sel=11 in the same cycle.
REQ-038 On the mret edge: MIE<=MPIE; MPIE<=1.
REQ-039 The mtvec and mepc outputs SHALL present register values, with trap updates visible in the following cycle.
REQ-040 pc_sel SHALL be 00 whenever neither ecall nor mret is asserted.
REQ-041 Priority for simultaneous events SHALL be ecall > mret > CSR write.
REQ-042 A suppressed event SHALL have no side effects.
REQ-043 The mcycle increment SHALL continue regardless of ecall or mret.
REQ-044 csr_rdata SHALL be valid whenever csr_en=1, and SHALL be don't-care otherwise.

Reset
REQ-045 While rst=1, asynchronously: mtvec=MTVEC_RST, mepc=0, mcause=0, mstatus=32'h0000_1800, mcycle=mcycleh=0.
REQ-046 Outputs during reset SHALL be mtvec=MTVEC_RST, mepc=0, and pc_sel=00 when ecall=mret=0.
REQ-047 Reset asserted mid-trap or mid-write SHALL discard the pending update.
REQ-048 The first increment SHALL occur on the first rising edge after rst deasserts.

Verification
REQ-049 Write mtvec: csr_en, op=001, addr 0x305, rs1=0x8000_0103 -> next cycle mtvec=0x8000_0100; csr_rdata in the write cycle equals the prior value.
REQ-050 Trap entry: pc=0x8000_0040, MIE=1, ecall=1 -> pc_sel=01 that cycle; next cycle mepc=0x8000_0040, mcause=11, mstatus=0x0000_1880.
REQ-051 Return: after REQ-050, mret=1 -> pc_sel=11 and mepc output=0x8000_0040; next cycle mstatus=0x0000_1888.
REQ-052 Counter carry: write mcycle=0xFFFF_FFFF, mcycleh=0 -> one cycle later mcycle=0, mcycleh=1; RS 0xB00 with uimm=0 leaves the count running.
REQ-053 Simultaneous events: ecall=1, mret=1 and RW 0x341=0x1234 in one cycle -> pc_sel=01, mepc=pc, write discarded; unimplemented 0x7C0 reads 0, and RW 0xF11 leaves mvendorid unchanged.
REQ-054 Async reset: assert rst between edges during a trap -> all registers take reset values immediately with no clock edge; mcycle=1 one edge after release.
